// File: rtl/xsystem86_rom_arbiter.sv
// N-channel EPROM emulation arbiter: each 27xxx-style channel keeps a one-entry
// data/tag cache, refilled round-robin from one shared byte-wide external memory.
module xsystem86_rom_arbiter #(
  parameter int NUM_CHANNELS   = 4,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int EXT_ADDR_WIDTH = 20,
  parameter int WAIT_STATES    = 3,
  parameter logic [NUM_CHANNELS*EXT_ADDR_WIDTH-1:0] CH_BASE = '0,
  parameter logic [NUM_CHANNELS*ADDR_WIDTH-1:0]     CH_MASK = '1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [NUM_CHANNELS-1:0]            ch_ce_n,
  input  logic [NUM_CHANNELS-1:0]            ch_oe_n,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] ch_addr,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_data,
  output logic [NUM_CHANNELS-1:0]            ch_ready,
  output logic [EXT_ADDR_WIDTH-1:0]          ext_addr,
  output logic                               ext_ce_n,
  output logic                               ext_oe_n,
  input  logic [DATA_WIDTH-1:0]              ext_data,
  output logic                               busy
);

  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int SW = EXT_ADDR_WIDTH + ADDR_WIDTH;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                  state;
  logic [CW-1:0]           cur;
  logic [CW-1:0]           last_grant;
  logic [ADDR_WIDTH-1:0]   cur_tag;
  logic [3:0]              cnt;
  logic                    discard;
  logic [NUM_CHANNELS-1:0] valid;
  logic [ADDR_WIDTH-1:0]   tag      [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]   data_reg [NUM_CHANNELS];

  logic [ADDR_WIDTH-1:0]   maddr [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] hit;
  logic [NUM_CHANNELS-1:0] req;
  logic [CW-1:0]           cand;
  logic [CW-1:0]           gnt;
  logic                    gnt_valid;
  logic [SW-1:0]           next_ext;

  // Per-channel decode; a deselected or output-disabled channel floats high.
  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latches.
    ch_data = '1;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      maddr[k] = ch_addr[k*ADDR_WIDTH +: ADDR_WIDTH] & CH_MASK[k*ADDR_WIDTH +: ADDR_WIDTH];
      hit[k]   = valid[k] && (tag[k] == maddr[k]);
      req[k]   = !ch_ce_n[k] && !hit[k];
      if (!ch_ce_n[k] && !ch_oe_n[k])
        ch_data[k*DATA_WIDTH +: DATA_WIDTH] = data_reg[k];
    end
  end

  assign ch_ready = hit;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    gnt_valid = 1'b0;
    gnt       = last_grant;
    cand      = '0;
    for (int i = 1; i <= NUM_CHANNELS; i++) begin
      cand = CW'((int'(last_grant) + i) % NUM_CHANNELS);
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt       = cand;
      end
    end
  end

  assign next_ext = SW'(CH_BASE[gnt*EXT_ADDR_WIDTH +: EXT_ADDR_WIDTH]) + SW'(maddr[gnt]);

  // NOTE: state is updated with non-blocking assignments only, so every
  // read in this block sees the pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cur        <= '0;
      last_grant <= CW'(NUM_CHANNELS - 1);
      cur_tag    <= '0;
      cnt        <= '0;
      discard    <= 1'b0;
      ext_addr   <= '0;
      ext_ce_n   <= 1'b1;
      ext_oe_n   <= 1'b1;
      busy       <= 1'b0;
      valid      <= '0;
      // NOTE: the cache arrays are a few flops per channel, not a RAM macro,
      // so resetting them costs nothing and gives all-ones reads after reset.
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        tag[k]      <= '0;
        data_reg[k] <= '1;
      end
    end else begin
      if (flush)
        valid <= '0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            cur        <= gnt;
            cur_tag    <= maddr[gnt];
            last_grant <= gnt;
            ext_addr   <= next_ext[EXT_ADDR_WIDTH-1:0];
            ext_ce_n   <= 1'b0;
            ext_oe_n   <= 1'b0;
            cnt        <= 4'(WAIT_STATES);
            discard    <= 1'b0;
            busy       <= 1'b1;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (flush)
            discard <= 1'b1;
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // Capture always writes the tag latched at grant; a flush seen
            // during the access or on this edge leaves the entry invalid.
            data_reg[cur] <= ext_data;
            tag[cur]      <= cur_tag;
            valid[cur]    <= !discard && !flush;
            ext_ce_n      <= 1'b1;
            ext_oe_n      <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
